// File: rtl/firefly_sync_ctrl.sv
// Locks onto the slow flash input f0 and regenerates it as f1 with matching period and phase.
// Optional macro FIREFLY_DUTY_EN: f1 copies the measured f0 high time instead of a fixed 50 % duty.
module firefly_sync_ctrl #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 5_000_000,
  parameter int TOL     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f0,
  output logic             f1,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

  typedef enum logic [1:0] {IDLE, MEAS1, MEAS2, LOCK} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, f0s_q, rise_q, fall_q;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q, hi_lat_q;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d, phase_q, phase_d;
  logic [CNT_W-1:0] on_time, diff;
  logic             f1_q, f1_d, locked_q, match, timeout;

  // f0s_q is the synced level; rise_q/fall_q line up with its transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      f0s_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      hi_lat_q  <= '0;
    end else begin
      s1_q   <= f0;
      s2_q   <= s1_q;
      f0s_q  <= s2_q;
      rise_q <= s2_q & ~f0s_q;
      fall_q <= ~s2_q & f0s_q;
      if (rise_q)                   per_cnt_q <= ONE;
      else if (per_cnt_q != CNT_MAX) per_cnt_q <= per_cnt_q + ONE;
      if (rise_q)                            hi_cnt_q <= ONE;
      else if (f0s_q && hi_cnt_q != CNT_MAX) hi_cnt_q <= hi_cnt_q + ONE;
      if (fall_q) hi_lat_q <= hi_cnt_q;
    end
  end

  assign diff    = (per_cnt_q >= period_q) ? per_cnt_q - period_q : period_q - per_cnt_q;
  assign match   = (diff <= TOL_C);
  assign timeout = (per_cnt_q >= TO_C);

`ifdef FIREFLY_DUTY_EN
  assign on_time = high_d;
`else
  assign on_time = period_d >> 1;
`endif

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    case (state_q)
      IDLE:  if (rise_q) state_d = MEAS1;
      MEAS1: begin
        if (rise_q) begin
          period_d = per_cnt_q;
          high_d   = hi_lat_q;
          state_d  = MEAS2;
        end else if (timeout) state_d = IDLE;
      end
      default: begin  // MEAS2 and LOCK share the compare-and-update step
        if (rise_q) begin
          period_d = per_cnt_q;
          high_d   = hi_lat_q;
          state_d  = match ? LOCK : MEAS2;
        end else if (timeout) state_d = IDLE;
      end
    endcase

    phase_d = '0;
    if (state_d == LOCK && !rise_q && (phase_q + ONE) < period_q) phase_d = phase_q + ONE;

    // f1 is computed from next-state values so it rises one clk after the synced rise
    f1_d = 1'b0;
    if (state_d == LOCK) begin
      if (period_d <= ONE || high_d == '0) f1_d = 1'b0;
      else if (high_d >= period_d)         f1_d = 1'b1;
      else                                 f1_d = (phase_d < on_time);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      phase_q  <= '0;
      f1_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      phase_q  <= phase_d;
      f1_q     <= f1_d;
      locked_q <= (state_d == LOCK);
    end
  end

  assign f1        = f1_q;
  assign locked    = locked_q;
  assign period    = period_q;
  assign high_time = high_q;

endmodule

// File: tb/tb_firefly_sync_ctrl.sv
// Directed bench for firefly_sync_ctrl: table of f0 periods plus timeout and reset sequences.
module tb_firefly_sync_ctrl;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 8000;
`ifdef FIREFLY_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f0;
  logic             f1, locked;
  logic [CNT_W-1:0] period, high_time;

  int n_chk  = 0;
  int n_fail = 0;

  firefly_sync_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(16)) dut (
    .clk(clk), .rst_n(rst_n), .f0(f0), .f1(f1), .locked(locked),
    .period(period), .high_time(high_time)
  );

  always #10 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    bit exp_lk;
    int exp_per;
    int exp_hi;
    bit chk_f1;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one f0 period starting with its rising edge; counts f1 samples over the same window
  task automatic run_vec(input int hi, input int lo, output int cnt);
    cnt = 0;
    for (int i = 0; i < hi + lo; i++) begin
      f0 = (i < hi);
      @(negedge clk);
      cnt += int'(f1);
    end
  endtask

  task automatic chk_state(input string nm, input bit lk, input int per, input int hi);
    chk({nm, ".locked"}, int'(locked), int'(lk));
    chk({nm, ".period"}, int'(period), per);
    chk({nm, ".high_time"}, int'(high_time), hi);
  endtask

  vec_t vecs[13];

  initial begin
    int cnt, exp_f1;
    // measured values always reflect the previous period, since the rise closes it
    vecs = '{
      '{2000,  500, 1'b0,    0,    0, 1'b1},  // first rise: IDLE -> MEAS1
      '{2000,  500, 1'b0, 2500, 2000, 1'b1},  // first measurement
      '{2000,  500, 1'b1, 2500, 2000, 1'b1},  // match -> LOCK
      '{2000,  500, 1'b1, 2500, 2000, 1'b1},
      '{1750,  750, 1'b1, 2500, 2000, 1'b1},  // duty sweep
      '{1500, 1000, 1'b1, 2500, 1750, 1'b1},
      '{1000, 1500, 1'b1, 2500, 1500, 1'b1},
      '{1250, 1250, 1'b1, 2500, 1000, 1'b1},
      '{1250, 1250, 1'b1, 2500, 1250, 1'b1},
      '{1500, 1500, 1'b1, 2500, 1250, 1'b0},  // period grows; still measures 2500
      '{1500, 1500, 1'b0, 3000, 1500, 1'b0},  // 3000 vs 2500 -> lock lost
      '{1500, 1500, 1'b1, 3000, 1500, 1'b1},  // relock
      '{1500, 1500, 1'b1, 3000, 1500, 1'b1}
    };

    rst_n = 1'b0;
    f0    = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset.f1", int'(f1), 0);
    chk_state("reset", 1'b0, 0, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle.f1", int'(f1), 0);
    chk_state("idle", 1'b0, 0, 0);

    foreach (vecs[i]) begin
      run_vec(vecs[i].hi, vecs[i].lo, cnt);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_lk, vecs[i].exp_per, vecs[i].exp_hi);
      if (vecs[i].chk_f1) begin
        exp_f1 = !vecs[i].exp_lk ? 0 : (DUTY ? vecs[i].exp_hi : vecs[i].exp_per / 2);
        chk($sformatf("vec%0d.f1_high", i), cnt, exp_f1);
      end
    end

    // f0 stops: last rise was ~3000 cycles ago, drop expected ~TIMEOUT after it
    f0 = 1'b0;
    repeat (TIMEOUT - 3100) @(negedge clk);
    chk("pre_timeout.locked", int'(locked), 1);
    repeat (200) @(negedge clk);
    chk("timeout.f1", int'(f1), 0);
    chk_state("timeout", 1'b0, 3000, 1500);

    // recovery walks MEAS1 -> MEAS2 -> LOCK again
    run_vec(1500, 1500, cnt);
    chk_state("rearm_meas1", 1'b0, 3000, 1500);
    run_vec(1500, 1500, cnt);
    chk_state("rearm_meas2", 1'b0, 3000, 1500);
    run_vec(1500, 1500, cnt);
    chk_state("rearm_lock", 1'b1, 3000, 1500);
    chk("rearm_lock.f1_high", cnt, 1500);

    // single-cycle reset while f1 is high in LOCK
    run_vec(100, 0, cnt);
    chk("pre_rst.f1", int'(f1), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst.f1", int'(f1), 0);
    chk_state("mid_rst", 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
